// File: rtl/adpcm_pkg.sv
// rtl/adpcm_pkg.sv - shared IMA ADPCM tables, limits and FSM state type
// Used by both the compressor and the decoder so both ends share one step table.
package adpcm_pkg;

   localparam int IDX_MAX = 88;
   localparam int PCM_MAX = 32767;
   localparam int PCM_MIN = -32768;

   localparam logic [14:0] STEP [0:88] = '{
      15'd7,     15'd8,     15'd9,     15'd10,    15'd11,    15'd12,    15'd13,    15'd14,
      15'd16,    15'd17,    15'd19,    15'd21,    15'd23,    15'd25,    15'd28,    15'd31,
      15'd34,    15'd37,    15'd41,    15'd45,    15'd50,    15'd55,    15'd60,    15'd66,
      15'd73,    15'd80,    15'd88,    15'd97,    15'd107,   15'd118,   15'd130,   15'd143,
      15'd157,   15'd173,   15'd190,   15'd209,   15'd230,   15'd253,   15'd279,   15'd307,
      15'd337,   15'd371,   15'd408,   15'd449,   15'd494,   15'd544,   15'd598,   15'd658,
      15'd724,   15'd796,   15'd876,   15'd963,   15'd1060,  15'd1166,  15'd1282,  15'd1411,
      15'd1552,  15'd1707,  15'd1878,  15'd2066,  15'd2272,  15'd2499,  15'd2749,  15'd3024,
      15'd3327,  15'd3660,  15'd4026,  15'd4428,  15'd4871,  15'd5358,  15'd5894,  15'd6484,
      15'd7132,  15'd7845,  15'd8630,  15'd9493,  15'd10442, 15'd11487, 15'd12635, 15'd13899,
      15'd15289, 15'd16818, 15'd18500, 15'd20350, 15'd22385, 15'd24623, 15'd27086, 15'd29794,
      15'd32767
   };

   // Index adjustment by code magnitude; the sign bit does not affect the index.
   localparam logic signed [4:0] IDX_ADJ [0:7] = '{
      -5'sd1, -5'sd1, -5'sd1, -5'sd1, 5'sd2, 5'sd4, 5'sd6, 5'sd8
   };

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_ACC0 = 2'd1,
      ST_ACC1 = 2'd2,
      ST_UPD  = 2'd3
   } dec_state_e;

endpackage

// File: rtl/adpcm_step_rom.sv
// rtl/adpcm_step_rom.sv - combinational step-index to step-size lookup
module adpcm_step_rom
   import adpcm_pkg::*;
(
   input  logic [6:0]  idx_i,
   output logic [14:0] step_o
);

   always_comb begin
      step_o = STEP[IDX_MAX];
      if (idx_i <= 7'(IDX_MAX)) begin
         step_o = STEP[idx_i];
      end
   end

endmodule

// File: rtl/adpcm_decoder.sv
// rtl/adpcm_decoder.sv - IMA ADPCM decoder, one 4-bit code per 4 clocks to 16-bit PCM
// Optional block-header resync preset enabled by defining ADPCM_DEC_PRESET_EN.
module adpcm_decoder
   import adpcm_pkg::*;
#(
   parameter int PCM_W = 16
)
(
   input  logic                    clk,
   input  logic                    rst,
   input  logic                    in_valid,
   output logic                    in_ready,
   input  logic [3:0]              code_in,
`ifdef ADPCM_DEC_PRESET_EN
   input  logic                    preset_valid,
   input  logic signed [15:0]      preset_pcm,
   input  logic [6:0]              preset_idx,
`endif
   output logic                    out_valid,
   output logic signed [PCM_W-1:0] pcm_out,
   output logic [6:0]              idx_out
);

   if (PCM_W != 16) begin : g_bad_pcm_w
      $error("adpcm_decoder: PCM_W must be 16");
   end

   localparam logic signed [8:0]  IDX_HI = 9'(IDX_MAX);
   localparam logic signed [17:0] SAT_HI = 18'(PCM_MAX);
   localparam logic signed [17:0] SAT_LO = 18'(PCM_MIN);

   dec_state_e         state_q, state_d;
   logic [3:0]         code_q, code_d;
   logic [14:0]        step_q, step_d;
   logic [16:0]        diff_q, diff_d;
   logic signed [15:0] pred_q, pred_d;
   logic [6:0]         idx_q, idx_d;
   logic signed [15:0] pcm_q, pcm_d;
   logic               out_valid_q, out_valid_d;

   logic [14:0]        rom_step;
   logic               preset_hit;
   logic signed [15:0] preset_pred;
   logic [6:0]         preset_idx_c;
   logic signed [17:0] pred_ext, diff_ext, pred_sum;
   logic signed [15:0] pred_sat;
   logic signed [8:0]  idx_sum;
   logic [6:0]         idx_clamped;

   adpcm_step_rom u_step_rom (
      .idx_i  (idx_q),
      .step_o (rom_step)
   );

`ifdef ADPCM_DEC_PRESET_EN
   assign preset_hit   = preset_valid && (state_q == ST_IDLE);
   assign preset_pred  = preset_pcm;
   assign preset_idx_c = (preset_idx > 7'(IDX_MAX)) ? 7'(IDX_MAX) : preset_idx;
`else
   assign preset_hit   = 1'b0;
   assign preset_pred  = pred_q;
   assign preset_idx_c = idx_q;
`endif

   assign in_ready  = (state_q == ST_IDLE) && !rst && !preset_hit;
   assign out_valid = out_valid_q;
   assign pcm_out   = pcm_q;
   assign idx_out   = idx_q;

   // 18-bit signed sum cannot overflow for |pred| <= 32768 and diff <= 61436.
   always_comb begin
      pred_ext = {{2{pred_q[15]}}, pred_q};
      diff_ext = {1'b0, diff_q};
      pred_sum = code_q[3] ? (pred_ext - diff_ext) : (pred_ext + diff_ext);
      if (pred_sum > SAT_HI) begin
         pred_sat = 16'(PCM_MAX);
      end else if (pred_sum < SAT_LO) begin
         pred_sat = 16'(PCM_MIN);
      end else begin
         pred_sat = pred_sum[15:0];
      end
   end

   always_comb begin
      idx_sum = $signed({2'b00, idx_q}) + 9'(IDX_ADJ[code_q[2:0]]);
      if (idx_sum < 9'sd0) begin
         idx_clamped = 7'd0;
      end else if (idx_sum > IDX_HI) begin
         idx_clamped = 7'(IDX_MAX);
      end else begin
         idx_clamped = idx_sum[6:0];
      end
   end

   always_comb begin
      state_d     = state_q;
      code_d      = code_q;
      step_d      = step_q;
      diff_d      = diff_q;
      pred_d      = pred_q;
      idx_d       = idx_q;
      pcm_d       = pcm_q;
      out_valid_d = 1'b0;
      case (state_q)
         ST_IDLE: begin
            if (preset_hit) begin
               pred_d = preset_pred;
               idx_d  = preset_idx_c;
            end else if (in_valid) begin
               code_d  = code_in;
               step_d  = rom_step;
               state_d = ST_ACC0;
            end
         end
         ST_ACC0: begin
            diff_d  = {2'b00, step_q >> 3} + (code_q[2] ? {2'b00, step_q} : 17'd0);
            state_d = ST_ACC1;
         end
         ST_ACC1: begin
            diff_d  = diff_q
                    + (code_q[1] ? {2'b00, step_q >> 1} : 17'd0)
                    + (code_q[0] ? {2'b00, step_q >> 2} : 17'd0);
            state_d = ST_UPD;
         end
         ST_UPD: begin
            pred_d      = pred_sat;
            pcm_d       = pred_sat;
            idx_d       = idx_clamped;
            out_valid_d = 1'b1;
            state_d     = ST_IDLE;
         end
         default: state_d = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= ST_IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         code_q      <= 4'd0;
         step_q      <= 15'd0;
         diff_q      <= 17'd0;
         pred_q      <= 16'sd0;
         idx_q       <= 7'd0;
         pcm_q       <= 16'sd0;
         out_valid_q <= 1'b0;
      end else begin
         code_q      <= code_d;
         step_q      <= step_d;
         diff_q      <= diff_d;
         pred_q      <= pred_d;
         idx_q       <= idx_d;
         pcm_q       <= pcm_d;
         out_valid_q <= out_valid_d;
      end
   end

endmodule

// File: tb/tb_adpcm_decoder.sv
// tb/tb_adpcm_decoder.sv - directed-vector self-checking bench for adpcm_decoder
module tb_adpcm_decoder;

   logic               clk = 1'b0;
   logic               rst;
   logic               in_valid;
   logic               in_ready;
   logic [3:0]         code_in;
   logic               out_valid;
   logic signed [15:0] pcm_out;
   logic [6:0]         idx_out;
`ifdef ADPCM_DEC_PRESET_EN
   logic               preset_valid;
   logic signed [15:0] preset_pcm;
   logic [6:0]         preset_idx;
`endif

   int checks = 0;
   int errors = 0;

   always #5 clk = ~clk;

   adpcm_decoder #(.PCM_W(16)) dut (
      .clk          (clk),
      .rst          (rst),
      .in_valid     (in_valid),
      .in_ready     (in_ready),
      .code_in      (code_in),
`ifdef ADPCM_DEC_PRESET_EN
      .preset_valid (preset_valid),
      .preset_pcm   (preset_pcm),
      .preset_idx   (preset_idx),
`endif
      .out_valid    (out_valid),
      .pcm_out      (pcm_out),
      .idx_out      (idx_out)
   );

   task automatic chk(input string tag, input int got, input int exp);
      checks++;
      if (got != exp) begin
         errors++;
         $display("FAIL %s got %0d expected %0d", tag, got, exp);
      end
   endtask

   task automatic do_reset();
      rst      = 1'b1;
      in_valid = 1'b0;
      code_in  = 4'd0;
      @(posedge clk); #1;
      @(posedge clk); #1;
      chk("rst_in_ready", int'(in_ready), 0);
      chk("rst_out_valid", int'(out_valid), 0);
      chk("rst_pcm", int'(pcm_out), 0);
      chk("rst_idx", int'(idx_out), 0);
      rst = 1'b0;
      #1;
      chk("rst_ready_after", int'(in_ready), 1);
   endtask

   // Present one code, wait for acceptance, return cycles until out_valid.
   task automatic run_code(input logic [3:0] c, output int lat);
      int n;
      code_in  = c;
      in_valid = 1'b1;
      n = 0;
      while (!in_ready && n < 20) begin
         @(posedge clk); #1;
         n++;
      end
      @(posedge clk); #1;
      in_valid = 1'b0;
      lat = 0;
      while (!out_valid && lat < 10) begin
         @(posedge clk); #1;
         lat++;
      end
   endtask

   logic [3:0] t1_code [3] = '{4'h4, 4'h7, 4'hC};
   int         t1_pcm  [3] = '{7, 23, 2};
   int         t1_idx  [3] = '{2, 10, 12};

   initial begin
      int lat;
      int ov_seen;
      rst      = 1'b1;
      in_valid = 1'b0;
      code_in  = 4'd0;
`ifdef ADPCM_DEC_PRESET_EN
      preset_valid = 1'b0;
      preset_pcm   = 16'sd0;
      preset_idx   = 7'd0;
`endif

      do_reset();
      for (int i = 0; i < 3; i++) begin
         run_code(t1_code[i], lat);
         chk("t1_latency", lat, 3);
         chk("t1_pcm", int'(pcm_out), t1_pcm[i]);
         chk("t1_idx", int'(idx_out), t1_idx[i]);
      end

      do_reset();
      run_code(4'h0, lat);
      chk("t2_latency", lat, 3);
      chk("t2_pcm", int'(pcm_out), 0);
      chk("t2_idx", int'(idx_out), 0);

      // in_valid held high; codes offered while busy must be ignored.
      do_reset();
      in_valid = 1'b1;
      for (int i = 0; i <= 8; i++) begin
         code_in = (i % 4 == 0) ? 4'h4 : 4'hF;
         if (i == 8) in_valid = 1'b0;
         if (i < 8) chk("t4_in_ready", int'(in_ready), int'(i % 4 == 0));
         chk("t4_out_valid", int'(out_valid), int'(i == 4 || i == 8));
         if (i == 4) begin
            chk("t4_pcm_a", int'(pcm_out), 7);
            chk("t4_idx_a", int'(idx_out), 2);
         end
         if (i == 8) begin
            chk("t4_pcm_b", int'(pcm_out), 17);
            chk("t4_idx_b", int'(idx_out), 4);
         end
         @(posedge clk); #1;
      end

      // Abort a decode with rst while in ACC1.
      code_in  = 4'h4;
      in_valid = 1'b1;
      @(posedge clk); #1;
      in_valid = 1'b0;
      @(posedge clk); #1;
      rst = 1'b1;
      @(posedge clk); #1;
      chk("t5_out_valid", int'(out_valid), 0);
      chk("t5_pcm", int'(pcm_out), 0);
      chk("t5_idx", int'(idx_out), 0);
      rst = 1'b0;
      #1;
      chk("t5_in_ready", int'(in_ready), 1);
      ov_seen = 0;
      for (int i = 0; i < 6; i++) begin
         @(posedge clk); #1;
         if (out_valid) ov_seen++;
      end
      chk("t5_no_out_valid", ov_seen, 0);

      do_reset();
      for (int k = 1; k <= 20; k++) begin
         run_code(4'h7, lat);
         chk("t3_latency", lat, 3);
         chk("t3_idx", int'(idx_out), (k * 8 > 88) ? 88 : k * 8);
      end
      chk("t3_pcm_sat", int'(pcm_out), 32767);
      run_code(4'hF, lat);
      chk("t3_neg_pcm", int'(pcm_out), -28669);
      chk("t3_neg_idx", int'(idx_out), 88);

`ifdef ADPCM_DEC_PRESET_EN
      do_reset();
      preset_valid = 1'b1;
      preset_pcm   = 16'sd1000;
      preset_idx   = 7'd100;
      in_valid     = 1'b1;
      code_in      = 4'h7;
      #1;
      chk("t6_ready_preset", int'(in_ready), 0);
      @(posedge clk); #1;
      preset_valid = 1'b0;
      in_valid     = 1'b0;
      chk("t6_idx", int'(idx_out), 88);
      chk("t6_out_valid", int'(out_valid), 0);
      chk("t6_pcm_hold", int'(pcm_out), 0);
      chk("t6_ready_after", int'(in_ready), 1);
      run_code(4'h0, lat);
      chk("t6_latency", lat, 3);
      chk("t6_pcm", int'(pcm_out), 5095);
      chk("t6_idx_next", int'(idx_out), 87);
`endif

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
